// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types, constants and geometry helpers for the L2 page-fill server
package l2_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_FETCH,
        ST_DELIVER,
        ST_GAP
    } l2_state_t;

    // Client indices; lower index wins arbitration
    localparam logic L2_C0 = 1'b0;   // dcache
    localparam logic L2_C1 = 1'b1;   // icache

    // Memory words are 16 bits, so a page holds half as many words as bytes
    function automatic int page_words_f(input int page_bytes);
        return page_bytes / 2;
    endfunction

    function automatic int offset_bits_f(input int page_bytes);
        return $clog2(page_bytes);
    endfunction

endpackage

// File: rtl/l2_arb.sv
// rtl/l2_arb.sv - fixed-priority request picker, lowest index wins
// Ports:
//   req         : one request bit per client
//   grant_valid : at least one request present
//   grant_id    : index of the winning client
module l2_arb #(
    parameter int N_CLIENTS = 2,
    parameter int ID_W      = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic [N_CLIENTS-1:0] req,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id
);

    // Scan from the top down so the lowest requesting index is the last write
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/l2_server.sv
// rtl/l2_server.sv - L2 page-fill responder serving two cache clients from a word memory
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   cN_start, cN_page            : client fill request and page number (c0 has priority)
//   cN_launch, cN_ready          : grant held for the transfer, one-cycle word-valid pulse
//   l2_busy, l2_data             : shared transfer-in-progress flag and returned word
//   mem_req, mem_addr            : word read request held until acknowledged, {page, word_idx}
//   mem_ack, mem_rdata           : read data valid strobe and data
module l2_server
    import l2_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int PAGE_BYTES = 32
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            c0_start,
    input  logic [ADDR_WIDTH-offset_bits_f(PAGE_BYTES)-1:0] c0_page,
    output logic                                            c0_launch,
    output logic                                            c0_ready,
    input  logic                                            c1_start,
    input  logic [ADDR_WIDTH-offset_bits_f(PAGE_BYTES)-1:0] c1_page,
    output logic                                            c1_launch,
    output logic                                            c1_ready,
    output logic                                            l2_busy,
    output logic [15:0]                                     l2_data,
    output logic                                            mem_req,
    output logic [ADDR_WIDTH-2:0]                           mem_addr,
    input  logic                                            mem_ack,
    input  logic [15:0]                                     mem_rdata
);

    localparam int PAGE_WORDS  = page_words_f(PAGE_BYTES);
    localparam int OFFSET_BITS = offset_bits_f(PAGE_BYTES);
    localparam int PAGE_W      = ADDR_WIDTH - OFFSET_BITS;
    localparam int IDX_W       = $clog2(PAGE_WORDS);

    l2_state_t         state_q, state_d;
    logic              owner_q, owner_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        launch_q, launch_d;
    logic [1:0]        ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [15:0]       data_q, data_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-2:0] mem_addr_q, mem_addr_d;

    logic grant_valid;
    logic grant_id;

    l2_arb #(
        .N_CLIENTS (2),
        .ID_W      (1)
    ) u_arb (
        .req         ({c1_start, c0_start}),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        page_d     = page_q;
        idx_d      = idx_q;
        launch_d   = launch_q;
        ready_d    = 2'b00;          // ready is a single-cycle pulse
        busy_d     = busy_q;
        data_d     = data_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d            = grant_id;
                    page_d             = (grant_id == L2_C1) ? c1_page : c0_page;
                    idx_d              = '0;
                    launch_d           = 2'b00;
                    launch_d[grant_id] = 1'b1;
                    busy_d             = 1'b1;
                    state_d            = ST_GRANT;
                end
            end
            ST_GRANT: begin
                mem_req_d  = 1'b1;
                mem_addr_d = {page_q, idx_q};
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    data_d           = mem_rdata;
                    ready_d[owner_q] = 1'b1;
                    mem_req_d        = 1'b0;
                    state_d          = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (idx_q == IDX_W'(PAGE_WORDS - 1)) begin
                    launch_d  = 2'b00;
                    busy_d    = 1'b0;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {page_q, idx_q + 1'b1};
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= L2_C0;
            page_q     <= '0;
            idx_q      <= '0;
            launch_q   <= 2'b00;
            ready_q    <= 2'b00;
            busy_q     <= 1'b0;
            data_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            launch_q   <= launch_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign c0_launch = launch_q[L2_C0];
    assign c1_launch = launch_q[L2_C1];
    assign c0_ready  = ready_q[L2_C0];
    assign c1_ready  = ready_q[L2_C1];
    assign l2_busy   = busy_q;
    assign l2_data   = data_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_l2_server.sv
// tb/tb_l2_server.sv - directed self-checking bench for l2_server
module tb_l2_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0_start, c1_start;
    logic [10:0] c0_page, c1_page;
    logic        c0_launch, c0_ready, c1_launch, c1_ready;
    logic        l2_busy;
    logic [15:0] l2_data;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // memory responder controls
    int lat_mode = 0;
    int ack_cnt  = 0;
    int wcnt     = 0;
    int cur_lat;

    // observations from one transfer
    int          obs_launch_at, obs_req_at, obs_rdy_at, obs_nrdy, obs_busy_n;
    int          obs_other, obs_consec, obs_noack, obs_unstable, obs_req_n, obs_launch_bad;
    bit          obs_done;
    logic [15:0] obs_words [0:15];

    always #5 clk = ~clk;

    l2_server dut (
        .clk       (clk),
        .rst       (rst),
        .c0_start  (c0_start),
        .c0_page   (c0_page),
        .c0_launch (c0_launch),
        .c0_ready  (c0_ready),
        .c1_start  (c1_start),
        .c1_page   (c1_page),
        .c1_launch (c1_launch),
        .c1_ready  (c1_ready),
        .l2_busy   (l2_busy),
        .l2_data   (l2_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Word memory: data equals address; latency per word cycles 0,1,5 when lat_mode is set
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_cnt % 3)
                0:       cur_lat = 0;
                1:       cur_lat = 1;
                default: cur_lat = 5;
            endcase
            if (lat_mode == 0) cur_lat = 0;
            if (rst || !mem_req) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (wcnt >= cur_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = {1'b0, mem_addr};
                wcnt      = 0;
                ack_cnt++;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Samples on falling edges from the grant onward until l2_busy falls or the budget ends
    task automatic observe(input int owner, input bit drop_early, input int budget);
        logic own_l, own_r, oth_l, oth_r;
        logic prev_rdy, prev_ack, prev_req;
        logic [14:0] prev_addr;
        bit seen_busy;
        obs_launch_at = -1; obs_req_at = -1; obs_rdy_at = -1;
        obs_nrdy = 0; obs_busy_n = 0; obs_other = 0; obs_consec = 0; obs_noack = 0;
        obs_unstable = 0; obs_req_n = 0; obs_launch_bad = 0; obs_done = 0;
        prev_rdy = 0; prev_ack = 0; prev_req = 0; prev_addr = '0; seen_busy = 0;
        for (int i = 0; i < 16; i++) obs_words[i] = 16'hxxxx;
        for (int s = 1; s <= budget && !obs_done; s++) begin
            @(negedge clk);
            own_l = (owner == 1) ? c1_launch : c0_launch;
            own_r = (owner == 1) ? c1_ready  : c0_ready;
            oth_l = (owner == 1) ? c0_launch : c1_launch;
            oth_r = (owner == 1) ? c0_ready  : c1_ready;
            if (own_l && obs_launch_at < 0) obs_launch_at = s;
            if (mem_req && obs_req_at < 0) obs_req_at = s;
            if (own_r) begin
                if (obs_rdy_at < 0) obs_rdy_at = s;
                if (obs_nrdy < 16) obs_words[obs_nrdy] = l2_data;
                obs_nrdy++;
                if (prev_rdy) obs_consec++;
                if (!prev_ack) obs_noack++;
                if (drop_early) begin
                    if (owner == 1) c1_start = 1'b0; else c0_start = 1'b0;
                end
            end
            if (oth_l || oth_r) obs_other++;
            if (mem_req) obs_req_n++;
            if (mem_req && prev_req && !prev_ack && mem_addr != prev_addr) obs_unstable++;
            if (l2_busy) begin
                obs_busy_n++;
                seen_busy = 1;
                if (!own_l) obs_launch_bad++;
            end else if (seen_busy) begin
                obs_done = 1;
            end
            prev_rdy  = own_r;
            prev_ack  = mem_ack;
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
        if (owner == 1) c1_start = 1'b0; else c0_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c0_start = 0; c1_start = 0; c0_page = '0; c1_page = '0;
        repeat (3) @(negedge clk);
        checks++; if ({c0_launch, c1_launch, c0_ready, c1_ready} !== 4'b0) begin failures++; $display("FAIL reset_launch_ready: got %b expected 0000", {c0_launch, c1_launch, c0_ready, c1_ready}); end
        checks++; if (l2_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", l2_busy); end
        checks++; if (l2_data !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000", l2_data); end
        checks++; if (mem_req !== 1'b0 || mem_addr !== 15'h0) begin failures++; $display("FAIL reset_mem: got req=%b addr=%h expected 0/0000", mem_req, mem_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fill();
        c1_page = 11'h012; c1_start = 1'b1;
        observe(1, 0, 100);
        checks++; if (obs_done !== 1'b1) begin failures++; $display("FAIL single_done: got %0d expected 1", obs_done); end
        checks++; if (obs_launch_at != 1) begin failures++; $display("FAIL single_launch_at: got %0d expected 1", obs_launch_at); end
        checks++; if (obs_req_at != 2) begin failures++; $display("FAIL single_req_at: got %0d expected 2", obs_req_at); end
        checks++; if (obs_rdy_at != 3) begin failures++; $display("FAIL single_ready_at: got %0d expected 3", obs_rdy_at); end
        checks++; if (obs_nrdy != 16) begin failures++; $display("FAIL single_ready_count: got %0d expected 16", obs_nrdy); end
        checks++; if (obs_busy_n != 49) begin failures++; $display("FAIL single_busy_cycles: got %0d expected 49", obs_busy_n); end
        checks++; if (obs_other != 0) begin failures++; $display("FAIL single_c0_activity: got %0d expected 0", obs_other); end
        checks++; if (obs_consec != 0 || obs_launch_bad != 0) begin failures++; $display("FAIL single_pulse_shape: got consec=%0d launch_bad=%0d expected 0/0", obs_consec, obs_launch_bad); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (obs_words[k] !== 16'h0120 + 16'(k)) begin failures++; $display("FAIL single_word%0d: got %h expected %h", k, obs_words[k], 16'h0120 + 16'(k)); end
        end
    endtask

    task automatic test_collision();
        c0_page = 11'h003; c1_page = 11'h7F0;
        c0_start = 1'b1; c1_start = 1'b1;
        observe(0, 1, 100);
        checks++; if (obs_done !== 1'b1 || obs_nrdy != 16) begin failures++; $display("FAIL coll_c0_done: got done=%0d words=%0d expected 1/16", obs_done, obs_nrdy); end
        checks++; if (obs_other != 0) begin failures++; $display("FAIL coll_c1_idle: got %0d expected 0", obs_other); end
        checks++; if (obs_words[0] !== 16'h0030 || obs_words[15] !== 16'h003F) begin failures++; $display("FAIL coll_c0_words: got %h/%h expected 0030/003F", obs_words[0], obs_words[15]); end
        observe(1, 0, 100);
        checks++; if (obs_launch_at != 1) begin failures++; $display("FAIL coll_c1_launch_at: got %0d expected 1", obs_launch_at); end
        checks++; if (obs_done !== 1'b1 || obs_nrdy != 16) begin failures++; $display("FAIL coll_c1_done: got done=%0d words=%0d expected 1/16", obs_done, obs_nrdy); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (obs_words[k] !== 16'h7F00 + 16'(k)) begin failures++; $display("FAIL coll_c1_word%0d: got %h expected %h", k, obs_words[k], 16'h7F00 + 16'(k)); end
        end
    endtask

    task automatic test_mem_latency();
        lat_mode = 1; ack_cnt = 0;
        c1_page = 11'h2C4; c1_start = 1'b1;
        observe(1, 0, 200);
        lat_mode = 0;
        checks++; if (obs_done !== 1'b1 || obs_nrdy != 16) begin failures++; $display("FAIL lat_done: got done=%0d words=%0d expected 1/16", obs_done, obs_nrdy); end
        checks++; if (obs_busy_n != 79) begin failures++; $display("FAIL lat_busy_cycles: got %0d expected 79", obs_busy_n); end
        checks++; if (obs_req_n != 46) begin failures++; $display("FAIL lat_req_cycles: got %0d expected 46", obs_req_n); end
        checks++; if (obs_unstable != 0) begin failures++; $display("FAIL lat_addr_stable: got %0d expected 0", obs_unstable); end
        checks++; if (obs_noack != 0 || obs_consec != 0) begin failures++; $display("FAIL lat_ready_per_ack: got noack=%0d consec=%0d expected 0/0", obs_noack, obs_consec); end
        checks++; if (obs_words[7] !== 16'h2C47 || obs_words[15] !== 16'h2C4F) begin failures++; $display("FAIL lat_words: got %h/%h expected 2C47/2C4F", obs_words[7], obs_words[15]); end
    endtask

    task automatic test_reset_mid();
        int nr;
        bit hit;
        nr = 0; hit = 0;
        c0_page = 11'h0AB; c0_start = 1'b1;
        for (int s = 0; s < 60 && !hit; s++) begin
            @(negedge clk);
            if (c0_ready) nr++;
            if (nr == 6) hit = 1;
        end
        checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_word5: got %0d words expected 6", nr); end
        c0_start = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if ({c0_launch, c0_ready, c1_launch, c1_ready, l2_busy, mem_req} !== 6'b0) begin failures++; $display("FAIL rstmid_async_flags: got %b expected 000000", {c0_launch, c0_ready, c1_launch, c1_ready, l2_busy, mem_req}); end
        checks++; if (l2_data !== 16'h0 || mem_addr !== 15'h0) begin failures++; $display("FAIL rstmid_async_data: got data=%h addr=%h expected 0/0", l2_data, mem_addr); end
        repeat (3) @(negedge clk);
        checks++; if (c0_ready !== 1'b0 || l2_busy !== 1'b0) begin failures++; $display("FAIL rstmid_held: got ready=%b busy=%b expected 0/0", c0_ready, l2_busy); end
        rst = 1'b0;
        c0_page = 11'h001; c0_start = 1'b1;
        observe(0, 0, 100);
        checks++; if (obs_launch_at != 1 || obs_rdy_at != 3) begin failures++; $display("FAIL rstmid_restart_timing: got launch=%0d ready=%0d expected 1/3", obs_launch_at, obs_rdy_at); end
        checks++; if (obs_done !== 1'b1 || obs_nrdy != 16) begin failures++; $display("FAIL rstmid_restart_done: got done=%0d words=%0d expected 1/16", obs_done, obs_nrdy); end
        checks++; if (obs_words[0] !== 16'h0010 || obs_words[15] !== 16'h001F) begin failures++; $display("FAIL rstmid_restart_words: got %h/%h expected 0010/001F", obs_words[0], obs_words[15]); end
    endtask

    task automatic test_start_dropped();
        c0_page = 11'h3AA; c0_start = 1'b1;
        observe(0, 1, 100);
        checks++; if (obs_nrdy != 16 || obs_done !== 1'b1) begin failures++; $display("FAIL drop_words: got %0d done=%0d expected 16/1", obs_nrdy, obs_done); end
        checks++; if (obs_busy_n != 49) begin failures++; $display("FAIL drop_busy_cycles: got %0d expected 49", obs_busy_n); end
        checks++; if (obs_words[15] !== 16'h3AAF) begin failures++; $display("FAIL drop_last_word: got %h expected 3AAF", obs_words[15]); end
    endtask

    task automatic test_back_to_back();
        c1_page = 11'h055; c1_start = 1'b1;
        observe(1, 0, 100);
        checks++; if (obs_done !== 1'b1 || obs_nrdy != 16) begin failures++; $display("FAIL b2b_first: got done=%0d words=%0d expected 1/16", obs_done, obs_nrdy); end
        c1_page = 11'h056; c1_start = 1'b1;
        observe(1, 0, 100);
        checks++; if (obs_launch_at != 1 || obs_rdy_at != 3) begin failures++; $display("FAIL b2b_second_timing: got launch=%0d ready=%0d expected 1/3", obs_launch_at, obs_rdy_at); end
        checks++; if (obs_nrdy != 16 || obs_other != 0) begin failures++; $display("FAIL b2b_second_pulses: got words=%0d other=%0d expected 16/0", obs_nrdy, obs_other); end
        checks++; if (obs_words[0] !== 16'h0560 || obs_words[15] !== 16'h056F) begin failures++; $display("FAIL b2b_second_words: got %h/%h expected 0560/056F", obs_words[0], obs_words[15]); end
        @(negedge clk);
        checks++; if ({c1_ready, c1_launch, l2_busy} !== 3'b000) begin failures++; $display("FAIL b2b_quiet_after: got %b expected 000", {c1_ready, c1_launch, l2_busy}); end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_collision();
        test_mem_latency();
        test_reset_mid();
        test_start_dropped();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
